switch_btn_reader: RTL and testbench

Input-side front end for the board's 16 slide switches and 4 active-low push buttons. It synchronizes and debounces the raw pad signals, then emits clean levels plus one-cycle press/release and switch-change events. It also latches the most recently pressed button as a group select. Its outputs feed the switch/LED group logic, which consumes only clean, debounced active-low buttons and stable switch levels.

---
 rtl/switch_btn_reader.sv | 159 +++++++++++++++
 tb/tb_switch_btn_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_btn_reader.sv
// switch_btn_reader: synchronizer and debouncer for the board's slide switches
// and active-low push buttons. It emits clean levels, one-cycle press/release
// and switch-change events, and a "last pressed button" group select.
// Optional build macro: BTN_AUTOREPEAT_EN. When it is defined, a button that
// stays held injects repeated btn_press pulses.
//
// Press FSM states:
//   state  | meaning
//   S_IDLE | no tracked button is held
//   S_HELD | the button at group_sel is held (and is the auto-repeat source)
module switch_btn_reader #(
    parameter int SW_W            = 16,
    parameter int BTN_W           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SW_W-1:0]          sw_raw,
    input  logic [BTN_W-1:0]         btn_raw_n,
    output logic [SW_W-1:0]          sw,
    output logic [BTN_W-1:0]         btn_n,
    output logic [BTN_W-1:0]         btn_press,
    output logic [BTN_W-1:0]         btn_release,
    output logic                     sw_changed,
    output logic [$clog2(BTN_W)-1:0] group_sel,
    output logic                     group_valid
);

    // Switches and buttons share one debounce path. Buttons occupy the top bits.
    localparam int N     = SW_W + BTN_W;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int GS_W  = $clog2(BTN_W);
    localparam logic [N-1:0] IDLE_LVL = {{BTN_W{1'b1}}, {SW_W{1'b0}}};

    typedef enum logic {S_IDLE, S_HELD} state_t;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("switch_btn_reader: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
    end

    logic [N-1:0]     raw_all;
    logic [N-1:0]     sync1;
    logic [N-1:0]     sync2;
    logic [N-1:0]     stable;
    logic [N-1:0]     acc;
    logic [CNT_W-1:0] cnt [N];
    logic [BTN_W-1:0] press_acc;
    logic [BTN_W-1:0] release_acc;
    logic             sw_acc;
    logic [BTN_W-1:0] rpt_press;
    state_t           state;

    assign raw_all = {btn_raw_n, sw_raw};
    assign sw      = stable[SW_W-1:0];
    assign btn_n   = stable[N-1:SW_W];

    function automatic logic [GS_W-1:0] lowest_idx(input logic [BTN_W-1:0] v);
        lowest_idx = '0;
        for (int i = BTN_W - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = GS_W'(i);
        end
    endfunction

    // Two-flop synchronizer, then per-bit run-length counter against the stable level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= IDLE_LVL;
            sync2  <= IDLE_LVL;
            stable <= IDLE_LVL;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw_all;
            sync2 <= sync1;
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == stable[i] || acc[i]) cnt[i] <= '0;
                else                                  cnt[i] <= cnt[i] + 1'b1;
                if (acc[i]) stable[i] <= sync2[i];
            end
        end
    end

    // A bit is accepted on the last differing sample of a full stable run.
    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            acc[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    assign press_acc   = acc[N-1:SW_W] &  stable[N-1:SW_W];
    assign release_acc = acc[N-1:SW_W] & ~stable[N-1:SW_W];
    assign sw_acc      = |acc[SW_W-1:0];

    // Event pulses, registered so they line up with the new stable levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_press   <= '0;
            btn_release <= '0;
            sw_changed  <= 1'b0;
        end else begin
            btn_press   <= press_acc | rpt_press;
            btn_release <= release_acc;
            sw_changed  <= sw_acc;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] hold_cnt;

    // Down-counter hits zero while still held and not being released or re-targeted.
    assign rpt_press = (state == S_HELD && hold_cnt == '0 && !release_acc[group_sel] && !(|press_acc))
                       ? (BTN_W'(1) << group_sel) : '0;
`else
    logic unused_state;

    assign rpt_press    = '0;
    // Without auto-repeat the press-tracking state has no consumer.
    assign unused_state = (state == S_HELD);
`endif

    // Press FSM with group select and (optionally) the hold timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            group_sel   <= '0;
            group_valid <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            hold_cnt    <= '0;
`endif
        end else if (|press_acc) begin
            state       <= S_HELD;
            group_sel   <= lowest_idx(press_acc);
            group_valid <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            hold_cnt    <= RPT_W'(REPEAT_DELAY - 1);
`endif
        end else if (state == S_HELD) begin
            if (release_acc[group_sel]) begin
                state <= S_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                hold_cnt <= '0;
`endif
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (hold_cnt == '0) begin
                hold_cnt <= RPT_W'(REPEAT_PERIOD - 1);
            end else begin
                hold_cnt <= hold_cnt - 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_switch_btn_reader.sv
// Bench for switch_btn_reader with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Expected events are queued with their due cycle when the
// pads are driven; a monitor pops and compares them whenever a pulse appears.
module tb_switch_btn_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw_raw;
    logic [3:0]  btn_raw_n;
    logic [15:0] sw;
    logic [3:0]  btn_n;
    logic [3:0]  btn_press;
    logic [3:0]  btn_release;
    logic        sw_changed;
    logic [1:0]  group_sel;
    logic        group_valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [15:0] sw;
        logic [3:0]  btn_n;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic        swchg;
        logic [1:0]  gsel;
        logic        valid;
    } ev_t;

    typedef struct {
        logic [15:0] sw_raw;
        logic [3:0]  btn;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic        swchg;
        logic [1:0]  gsel;
        logic        valid;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[12];

    switch_btn_reader #(
        .SW_W(16), .BTN_W(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .btn_raw_n(btn_raw_n),
        .sw(sw), .btn_n(btn_n), .btn_press(btn_press), .btn_release(btn_release),
        .sw_changed(sw_changed), .group_sel(group_sel), .group_valid(group_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic [15:0] s, input logic [3:0] b,
                           input logic [3:0] p, input logic [3:0] r, input logic sc,
                           input logic [1:0] g, input logic v);
        ev_t e;
        e.cyc = c; e.sw = s; e.btn_n = b; e.press = p; e.rel = r;
        e.swchg = sc; e.gsel = g; e.valid = v;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_event: got none at cycle %0d expected press=%h rel=%h swchg=%b",
                         e.cyc, e.press, e.rel, e.swchg);
            end
            if (btn_press != 0 || btn_release != 0 || sw_changed) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: got press=%h rel=%h swchg=%b at cycle %0d expected no event",
                             btn_press, btn_release, sw_changed, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("event@%0d", cyc),
                          {sw, btn_n, btn_press, btn_release, sw_changed, group_sel, group_valid},
                          {e.sw, e.btn_n, e.press, e.rel, e.swchg, e.gsel, e.valid});
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        //            sw_raw    btn     press    rel      swchg gsel valid
        vecs[0]  = '{16'h0000, 4'hF,    4'h0,    4'h0,    1'b1, 2'd0, 1'b0};
        vecs[1]  = '{16'h00FF, 4'hF,    4'h0,    4'h0,    1'b1, 2'd0, 1'b0};
        vecs[2]  = '{16'h00FF, 4'b1101, 4'b0010, 4'h0,    1'b0, 2'd1, 1'b1};
        vecs[3]  = '{16'h00FF, 4'hF,    4'h0,    4'b0010, 1'b0, 2'd1, 1'b1};
        vecs[4]  = '{16'h00FF, 4'b0011, 4'b1100, 4'h0,    1'b0, 2'd2, 1'b1};
        vecs[5]  = '{16'h00FF, 4'hF,    4'h0,    4'b1100, 1'b0, 2'd2, 1'b1};
        vecs[6]  = '{16'hA5A5, 4'hF,    4'h0,    4'h0,    1'b1, 2'd2, 1'b1};
        vecs[7]  = '{16'hA5A5, 4'b0111, 4'b1000, 4'h0,    1'b0, 2'd3, 1'b1};
        vecs[8]  = '{16'hA5A5, 4'hF,    4'h0,    4'b1000, 1'b0, 2'd3, 1'b1};
        vecs[9]  = '{16'h0000, 4'b1110, 4'b0001, 4'h0,    1'b1, 2'd0, 1'b1};
        vecs[10] = '{16'h0000, 4'b1100, 4'b0010, 4'h0,    1'b0, 2'd1, 1'b1};
        vecs[11] = '{16'h0000, 4'hF,    4'h0,    4'b0011, 1'b0, 2'd1, 1'b1};

        rst_n     = 1'b0;
        sw_raw    = 16'hFFFF;
        btn_raw_n = 4'h0;
        fork
            monitor();
        join_none

        // Reset with active pads, then the post-reset acceptance.
        tick(3);
        check("rst_sw", sw, 16'h0000);
        check("rst_btn_n", btn_n, 4'hF);
        check("rst_valid", group_valid, 1'b0);
        check("rst_gsel", group_sel, 2'd0);
        check("rst_pulses", {btn_press, btn_release, sw_changed}, 9'h0);
        rst_n = 1'b1;
        push_ev(cyc + 6, 16'hFFFF, 4'h0, 4'hF, 4'h0, 1'b1, 2'd0, 1'b1);
        tick(10);

        // Second reset with idle pads clears group_valid and yields no events.
        sw_raw    = 16'h0000;
        btn_raw_n = 4'hF;
        rst_n     = 1'b0;
        tick(2);
        check("rst2_valid", group_valid, 1'b0);
        check("rst2_lvl", {sw, btn_n}, {16'h0000, 4'hF});
        rst_n = 1'b1;
        tick(3);

        // Reset in the middle of a debounce run restarts it from scratch.
        sw_raw = 16'h00FF;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        push_ev(cyc + 6, 16'h00FF, 4'hF, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0);
        tick(10);
        check("middeb_sw", sw, 16'h00FF);

        for (int i = 0; i < 12; i++) begin
            sw_raw    = vecs[i].sw_raw;
            btn_raw_n = vecs[i].btn;
            push_ev(cyc + 6, vecs[i].sw_raw, vecs[i].btn, vecs[i].press, vecs[i].rel,
                    vecs[i].swchg, vecs[i].gsel, vecs[i].valid);
            tick(10);
            check($sformatf("vec%0d_lvl", i), {sw, btn_n, group_sel, group_valid},
                  {vecs[i].sw_raw, vecs[i].btn, vecs[i].gsel, vecs[i].valid});
        end

        // Three-sample glitch on button 2 is rejected.
        btn_raw_n = 4'b1011;
        tick(3);
        btn_raw_n = 4'hF;
        tick(10);
        check("glitch_lvl", {btn_n, group_sel}, {4'hF, 2'd1});

        // Four-sample pulse on button 0 is exactly long enough to be accepted.
        btn_raw_n = 4'b1110;
        push_ev(cyc + 6, 16'h0000, 4'b1110, 4'b0001, 4'h0, 1'b0, 2'd0, 1'b1);
        tick(4);
        btn_raw_n = 4'hF;
        push_ev(cyc + 6, 16'h0000, 4'hF, 4'h0, 4'b0001, 1'b0, 2'd0, 1'b1);
        tick(10);

        // Long hold on button 3: debounced low for 50 clocks after acceptance.
        btn_raw_n = 4'b0111;
        n = cyc;
        push_ev(n + 6, 16'h0000, 4'b0111, 4'b1000, 4'h0, 1'b0, 2'd3, 1'b1);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 0; k < 4; k++) begin
            push_ev(n + 26 + 8 * k, 16'h0000, 4'b0111, 4'b1000, 4'h0, 1'b0, 2'd3, 1'b1);
        end
`endif
        tick(50);
        btn_raw_n = 4'hF;
        push_ev(cyc + 6, 16'h0000, 4'hF, 4'h0, 4'b1000, 1'b0, 2'd3, 1'b1);
        tick(12);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
